// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU among NREQ requesters.
// Each transaction runs IDLE -> EXEC -> DONE with registered operands and results.
module alu_arbiter #(
   parameter int NREQ   = 2,
   parameter int OP_W   = 4,
   parameter int WORD_W = 32
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic [NREQ-1:0]                req,
   input  logic [NREQ-1:0][OP_W-1:0]      req_op,
   input  logic [NREQ-1:0][WORD_W-1:0]    req_a,
   input  logic [NREQ-1:0][WORD_W-1:0]    req_b,
   output logic [NREQ-1:0]                ack,
   output logic [WORD_W-1:0]              rsp_out,
   output logic                           rsp_zero,
   output logic                           rsp_neg,
   output logic                           rsp_ovf,
   output logic                           busy,
   output logic [OP_W-1:0]                alu_op_o,
   output logic [WORD_W-1:0]              alu_a_o,
   output logic [WORD_W-1:0]              alu_b_o,
   input  logic [WORD_W-1:0]              alu_out_i,
   input  logic                           alu_zero_i,
   input  logic                           alu_neg_i,
   input  logic                           alu_ovf_i
);

   localparam int IDX_W = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t              state_q;
   logic [IDX_W-1:0]    gnt_q, rr_ptr_q, gnt_d, rr_ptr_d;
   logic                found_d;
   logic [OP_W-1:0]     op_q;
   logic [WORD_W-1:0]   a_q, b_q, rsp_out_q;
   logic                rsp_zero_q, rsp_neg_q, rsp_ovf_q;
   logic [NREQ-1:0]     ack_q;
   logic                busy_q;

   // Scan downward so the requester closest to rr_ptr is the last (winning) match.
   always_comb begin
      gnt_d   = rr_ptr_q;
      found_d = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[(int'(rr_ptr_q) + i) % NREQ]) begin
            gnt_d   = IDX_W'((int'(rr_ptr_q) + i) % NREQ);
            found_d = 1'b1;
         end
      end
      rr_ptr_d = (gnt_q == IDX_W'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         rr_ptr_q   <= '0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         rsp_out_q  <= '0;
         rsp_zero_q <= 1'b0;
         rsp_neg_q  <= 1'b0;
         rsp_ovf_q  <= 1'b0;
         ack_q      <= '0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (found_d) begin
                  gnt_q   <= gnt_d;
                  op_q    <= req_op[gnt_d];
                  a_q     <= req_a[gnt_d];
                  b_q     <= req_b[gnt_d];
                  busy_q  <= 1'b1;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               rsp_out_q      <= alu_out_i;
               rsp_zero_q     <= alu_zero_i;
               rsp_neg_q      <= alu_neg_i;
               rsp_ovf_q      <= alu_ovf_i;
               ack_q          <= '0;
               ack_q[gnt_q]   <= 1'b1;
               state_q        <= DONE;
            end
            DONE: begin
               ack_q    <= '0;
               busy_q   <= 1'b0;
               rr_ptr_q <= rr_ptr_d;
               state_q  <= IDLE;
            end
            default: begin
               ack_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ack      = ack_q;
   assign busy     = busy_q;
   assign rsp_out  = rsp_out_q;
   assign rsp_zero = rsp_zero_q;
   assign rsp_neg  = rsp_neg_q;
   assign rsp_ovf  = rsp_ovf_q;
   assign alu_op_o = op_q;
   assign alu_a_o  = a_q;
   assign alu_b_o  = b_q;

   always @(posedge CLK) begin
      if (!RST) begin
         assert ($onehot0(ack_q));
         assert ((ack_q == '0) || (state_q == DONE));
         assert (busy_q == (state_q != IDLE));
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the alu_* side.
module tb_alu_arbiter;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_OR  = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        req;
   logic [1:0][3:0]   req_op;
   logic [1:0][31:0]  req_a, req_b;
   logic [1:0]        ack;
   logic [31:0]       rsp_out;
   logic              rsp_zero, rsp_neg, rsp_ovf, busy;
   logic [3:0]        alu_op;
   logic [31:0]       alu_a, alu_b, alu_out;
   logic              alu_zero, alu_neg, alu_ovf;

   int checks = 0;
   int passed = 0;

   alu_arbiter #(.NREQ(2), .OP_W(4), .WORD_W(32)) dut (
      .CLK(clk), .RST(rst), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .ack(ack), .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
      .rsp_ovf(rsp_ovf), .busy(busy), .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
      .alu_out_i(alu_out), .alu_zero_i(alu_zero), .alu_neg_i(alu_neg), .alu_ovf_i(alu_ovf)
   );

   always #5 clk = ~clk;

   // External ALU stand-in.
   always_comb begin
      alu_out = 32'd0;
      alu_ovf = 1'b0;
      case (alu_op)
         OP_ADD: begin
            alu_out = alu_a + alu_b;
            alu_ovf = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
         end
         OP_SUB: begin
            alu_out = alu_a - alu_b;
            alu_ovf = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
         end
         OP_OR:   alu_out = alu_a | alu_b;
         OP_AND:  alu_out = alu_a & alu_b;
         default: alu_out = 32'd0;
      endcase
      alu_zero = (alu_out == 32'd0);
      alu_neg  = alu_out[31];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 2'b11;
      req_op[0] = OP_ADD; req_a[0] = 32'd3; req_b[0] = 32'd4;
      req_op[1] = OP_OR;  req_a[1] = 32'h0;  req_b[1] = 32'h0;
      tick(); tick();
      checks++; if (ack !== 2'b00) $display("FAIL reset_ack got=%b exp=00", ack); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
      checks++; if (rsp_out !== 32'd0) $display("FAIL reset_rsp got=%h exp=0", rsp_out); else passed++;
      checks++; if (alu_a !== 32'd0) $display("FAIL reset_alu_a got=%h exp=0", alu_a); else passed++;
      rst = 1'b0;
      tick();
      checks++; if (busy !== 1'b1 || alu_a !== 32'd3) $display("FAIL first_grant_exec busy=%b alu_a=%h exp busy=1 alu_a=3", busy, alu_a); else passed++;
      tick();
      checks++; if (ack !== 2'b01) $display("FAIL first_grant_ack got=%b exp=01", ack); else passed++;
      checks++; if (rsp_out !== 32'd7) $display("FAIL first_grant_rsp got=%h exp=7", rsp_out); else passed++;
      req = 2'b00;
      tick();
      checks++; if (ack !== 2'b00 || busy !== 1'b0) $display("FAIL first_done_exit ack=%b busy=%b exp 00/0", ack, busy); else passed++;
   endtask

   task automatic test_single();
      req_op[1] = OP_ADD; req_a[1] = 32'h7FFF_FFFF; req_b[1] = 32'd1;
      req = 2'b10;
      tick();
      checks++; if (ack !== 2'b00) $display("FAIL single_exec_ack got=%b exp=00", ack); else passed++;
      tick();
      checks++; if (ack !== 2'b10) $display("FAIL single_ack got=%b exp=10", ack); else passed++;
      checks++; if (rsp_out !== 32'h8000_0000) $display("FAIL single_rsp got=%h exp=80000000", rsp_out); else passed++;
      checks++; if (rsp_ovf !== 1'b1 || rsp_neg !== 1'b1 || rsp_zero !== 1'b0)
         $display("FAIL single_flags got z=%b n=%b v=%b exp z=0 n=1 v=1", rsp_zero, rsp_neg, rsp_ovf); else passed++;
      req = 2'b00;
      tick();
      checks++; if (ack !== 2'b00 || busy !== 1'b0) $display("FAIL single_exit ack=%b busy=%b exp 00/0", ack, busy); else passed++;
      tick();
      checks++; if (rsp_out !== 32'h8000_0000) $display("FAIL single_hold got=%h exp=80000000", rsp_out); else passed++;
   endtask

   task automatic test_contention();
      logic [1:0] exp_ack;
      req_op[0] = OP_SUB; req_a[0] = 32'd5;     req_b[0] = 32'd5;
      req_op[1] = OP_OR;  req_a[1] = 32'h0F0;   req_b[1] = 32'h00F;
      req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
         tick(); tick();
         checks++; if (ack !== exp_ack) $display("FAIL contention_ack k=%0d got=%b exp=%b", k, ack, exp_ack); else passed++;
         if (k % 2 == 0) begin
            checks++; if (rsp_out !== 32'd0 || rsp_zero !== 1'b1) $display("FAIL contention_r0 k=%0d rsp=%h z=%b exp 0/1", k, rsp_out, rsp_zero); else passed++;
         end else begin
            checks++; if (rsp_out !== 32'h0FF || rsp_zero !== 1'b0) $display("FAIL contention_r1 k=%0d rsp=%h z=%b exp 0ff/0", k, rsp_out, rsp_zero); else passed++;
         end
         tick();
      end
      req = 2'b00;
      tick();
   endtask

   task automatic test_operand_change();
      req_op[0] = OP_ADD; req_a[0] = 32'd10; req_b[0] = 32'd1;
      req = 2'b01;
      tick();
      req_a[0] = 32'd99;
      tick();
      checks++; if (ack !== 2'b01 || rsp_out !== 32'd11) $display("FAIL operand_change ack=%b rsp=%0d exp 01/11", ack, rsp_out); else passed++;
      req = 2'b00;
      tick();
   endtask

   task automatic test_withdraw();
      req_op[0] = OP_ADD; req_a[0] = 32'd2; req_b[0] = 32'd3;
      req = 2'b01;
      tick();
      req = 2'b00;
      tick();
      checks++; if (ack !== 2'b01 || rsp_out !== 32'd5) $display("FAIL withdraw_ack ack=%b rsp=%0d exp 01/5", ack, rsp_out); else passed++;
      tick();
      tick();
      checks++; if (busy !== 1'b0 || ack !== 2'b00) $display("FAIL withdraw_idle busy=%b ack=%b exp 0/00", busy, ack); else passed++;
   endtask

   task automatic test_midop_reset();
      logic saw_ack;
      req_op[0] = OP_ADD; req_a[0] = 32'd20; req_b[0] = 32'd22;
      req = 2'b01;
      tick();
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || ack !== 2'b00 || alu_a !== 32'd0) $display("FAIL midreset_clear busy=%b ack=%b alu_a=%h exp 0/00/0", busy, ack, alu_a); else passed++;
      req = 2'b00;
      saw_ack = 1'b0;
      tick(); if (ack !== 2'b00) saw_ack = 1'b1;
      tick(); if (ack !== 2'b00) saw_ack = 1'b1;
      checks++; if (saw_ack !== 1'b0) $display("FAIL midreset_noack got=%b exp=0", saw_ack); else passed++;
      rst = 1'b0;
      req_op[0] = OP_ADD; req_a[0] = 32'd1;     req_b[0] = 32'd1;
      req_op[1] = OP_AND; req_a[1] = 32'hF0F0;  req_b[1] = 32'hFF00;
      req = 2'b11;
      tick(); tick();
      checks++; if (ack !== 2'b01 || rsp_out !== 32'd2) $display("FAIL midreset_rrptr ack=%b rsp=%h exp 01/2", ack, rsp_out); else passed++;
      req = 2'b00;
      tick();
      req = 2'b10;
      tick(); tick();
      checks++; if (ack !== 2'b10 || rsp_out !== 32'hF000) $display("FAIL midreset_req1 ack=%b rsp=%h exp 10/f000", ack, rsp_out); else passed++;
      req = 2'b00;
      tick();
   endtask

   task automatic test_back_to_back();
      req_op[1] = OP_SUB; req_a[1] = 32'h8000_0000; req_b[1] = 32'd1;
      req = 2'b10;
      tick(); tick();
      checks++; if (ack !== 2'b10 || rsp_out !== 32'h7FFF_FFFF || rsp_ovf !== 1'b1 || rsp_neg !== 1'b0)
         $display("FAIL b2b_first ack=%b rsp=%h v=%b n=%b exp 10/7fffffff/1/0", ack, rsp_out, rsp_ovf, rsp_neg); else passed++;
      tick();
      tick(); tick();
      checks++; if (ack !== 2'b10) $display("FAIL b2b_second ack=%b exp=10", ack); else passed++;
      req = 2'b00;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_operand_change();
      test_withdraw();
      test_midop_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
